uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first; sits directly upstream of the fault injector command parser.
- Converts the host serial line into one-cycle rx_done strobes with a parallel byte on rx_data.
- The fault injector samples rx_data only on rx_done. It also uses rx_done as the manual-trigger strobe, so pulse width and timing are contractual.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200). Legal range 4..65535. H = CLKS_PER_BIT/2, integer division.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  raw serial line, asynchronous to clk, idle high
- rx_done  output  1  one-cycle strobe: rx_data holds a newly received valid byte
- rx_data  output  8  last validly received byte; held until the next valid byte
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - rx_done=0, rx_data=8'h00, frame_err=0, rx_busy=0.
  - State IDLE; counters and shift register cleared.
  - Synchronizer flops reset to 1 so no false start is seen on release.
  - Reset mid-frame abandons the frame silently: no rx_done, no frame_err.
- Input sync: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Counters: bit-time counter is 16 bits; bit index is 3 bits.
- IDLE:
  - rx_s==0 -> START, counter=0.
- START:
  - counter==H-1 and rx_s==0 -> DATA, counter=0, bit_idx=0.
  - counter==H-1 and rx_s==1 -> IDLE (glitch rejected, no strobe).
  - Otherwise counter++.
- DATA:
  - counter==CLKS_PER_BIT-1 -> shift[bit_idx]=rx_s, counter=0.
  - On that sample, bit_idx==7 -> STOP; otherwise bit_idx++.
  - Otherwise counter++.
- STOP:
  - counter==CLKS_PER_BIT-1 and rx_s==1 -> rx_done=1, rx_data=shift (same edge), IDLE.
  - counter==CLKS_PER_BIT-1 and rx_s==0 -> frame_err=1, rx_data unchanged, BREAK.
- BREAK:
  - Wait for rx_s==1, then IDLE. No new start is detected while the line is held low.
- Strobes: rx_done and frame_err are registered, high exactly one cycle, never both high at once.
- Timing: let edge 0 be the first clk edge at which the synchronizer's first flop captures rx=0.
  - Start bit is validated at edge 2+H.
  - Data bit k is sampled at edge 2+H+(k+1)*CLKS_PER_BIT.
  - rx_done/frame_err are high in the cycle after edge 2+H+9*CLKS_PER_BIT.
- Back-to-back frames: return to IDLE at mid-stop bit leaves H cycles to catch the next falling edge, so no idle gap is required between frames.
- Baud tolerance: reception is correct for line rate error up to ±4%.
- rx_busy is combinational from state, glitch-free (decoded from registered state only).

Test Plan (CLKS_PER_BIT=16, H=8):
- Send 0xA0 (bits LSB first 0,0,0,0,0,1,0,1) then a valid stop bit.
  - rx_done high for exactly 1 cycle, following edge 154; rx_data=8'hA0; frame_err stays 0.
- Send 0xC0, 0x42, 0xFF back-to-back with zero idle bits.
  - Three rx_done pulses spaced 160 cycles apart.
  - rx_data=C0, 42, FF in order, each held until the next strobe.
- Drive a 4-cycle low glitch on idle rx.
  - rx_busy pulses; START aborts at the mid-start check; no rx_done, no frame_err.
- Send 0x55 with the stop bit low, hold rx low 100 cycles, then release and send 0x01.
  - frame_err one pulse; rx_data keeps its previous value.
  - No start detected during the hold.
  - After release, 0x01 is received with rx_done.
- Assert rst_n low during data bit 4 of 0xB1, release, then send 0xB2.
  - Outputs at reset values during reset; no strobe for 0xB1.
  - 0xB2 received correctly.
- Send 0x3C with bit period 15 and again with bit period 17 (±6.25%, beyond spec).
  - With CLKS_PER_BIT=32 and bit periods 31 and 33 (±3.1%), 0x3C is received correctly both times.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// Turns the asynchronous serial line into a one-cycle rx_done strobe with the
// received byte on rx_data, or a one-cycle frame_err strobe on a low stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_done,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    // Mid-start check point and full-bit sample point of the bit-time counter
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_n;
    logic [DATA_W-1:0] data_n;
    logic              done_n;
    logic              ferr_n;

    logic              rx_meta;
    logic              rx_s;

    // Two-flop synchronizer; resets to idle-high so release never looks like a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        data_n  = rx_data;
        done_n  = 1'b0;
        ferr_n  = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // A line that is high again by mid-start was only a glitch
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        done_n  = 1'b1;
                        data_n  = shift;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BRK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            BRK: begin
                // Hold off start detection until the line returns high
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Busy decoded from registered state only
    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance at 16 clocks/bit for the
// functional scenarios, one at 32 clocks/bit for the baud-tolerance check.
module tb_uart_rx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned H     = CPB / 2;
    localparam int unsigned CPB32 = 32;
    localparam int unsigned DONE_LAT = 2 + H + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx32;

    logic       rx_done;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       rx_busy;

    logic       d32_done;
    logic [7:0] d32_data;
    logic       d32_ferr;
    logic       d32_busy;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Scoreboard state (expected side lives only in the initial block)
    logic [7:0]  exp_q[$];
    logic [7:0]  exp32_q[$];
    int unsigned rd = 0;
    int unsigned rd32 = 0;

    // Observed side, written only by the monitor
    logic [7:0]  obs_data[$];
    int unsigned obs_cyc[$];
    int unsigned ferr_cyc[$];
    logic [7:0]  obs32[$];
    int unsigned ferr32_n = 0;
    int unsigned overlap_n = 0;
    int unsigned width_n = 0;
    int unsigned hold_n = 0;
    int unsigned busy_n = 0;
    logic        done_q = 1'b0;
    logic        ferr_q = 1'b0;
    logic [7:0]  data_q = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    uart_rx #(.CLKS_PER_BIT(CPB32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx32),
        .rx_done   (d32_done),
        .rx_data   (d32_data),
        .frame_err (d32_ferr),
        .rx_busy   (d32_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log strobes and strobe-protocol violations on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            done_q = 1'b0;
            ferr_q = 1'b0;
            data_q = rx_data;
        end else begin
            if (rx_done) begin
                obs_data.push_back(rx_data);
                obs_cyc.push_back(cyc);
            end
            if (frame_err) ferr_cyc.push_back(cyc);
            if (rx_done && frame_err) overlap_n++;
            if (rx_done && done_q) width_n++;
            if (frame_err && ferr_q) width_n++;
            if ((rx_data !== data_q) && !rx_done) hold_n++;
            if (rx_busy) busy_n++;
            done_q = rx_done;
            ferr_q = frame_err;
            data_q = rx_data;
            if (d32_done) obs32.push_back(d32_data);
            if (d32_ferr) ferr32_n++;
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int unsigned per, input bit sel);
        if (sel) rx32 = b;
        else     rx   = b;
        step(per);
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned per,
                              input logic stop, input bit sel);
        drive_bit(1'b0, per, sel);
        for (int i = 0; i < 8; i++) drive_bit(d[i], per, sel);
        drive_bit(stop, per, sel);
    endtask

    // Bounded wait for the 16-clk DUT to produce 'target' strobes in total
    task automatic wait_obs(input int unsigned target, input int unsigned budget);
        int unsigned b;
        b = budget;
        while (obs_data.size() < target && b > 0) begin
            @(posedge clk);
            b--;
        end
        #1;
        if (obs_data.size() < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_obs: strobes seen %0d, required %0d", obs_data.size(), target);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        rx32  = 1'b1;
        step(3);
        n_checks++;
        if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
        n_checks++;
        if ({d32_done, d32_data, d32_ferr, d32_busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_dut32: got %h want 000", {d32_done, d32_data, d32_ferr, d32_busy});
        end
        rst_n = 1'b1;
        step(6);
        n_checks++;
        if (rx_busy !== 1'b0 || busy_n != 0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy %b busy_cycles %0d want 0/0", rx_busy, busy_n);
        end
    endtask

    task automatic test_single;
        int unsigned t0;
        logic [7:0]  e;
        t0 = cyc;
        exp_q.push_back(8'hA0);
        send_frame(8'hA0, CPB, 1'b1, 1'b0);
        wait_obs(rd + 1, 50);
        if (obs_data.size() > rd) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_data[rd] !== e) begin n_fail++; $display("FAIL single_data: got %h want %h", obs_data[rd], e); end
            n_checks++;
            if (obs_cyc[rd] - t0 != DONE_LAT) begin
                n_fail++;
                $display("FAIL single_latency: got %0d want %0d", obs_cyc[rd] - t0, DONE_LAT);
            end
            rd++;
        end
        n_checks++;
        if (ferr_cyc.size() != 0) begin n_fail++; $display("FAIL single_no_ferr: got %0d want 0", ferr_cyc.size()); end
        n_checks++;
        if (width_n != 0) begin n_fail++; $display("FAIL single_pulse_width: violations %0d want 0", width_n); end
    endtask

    task automatic test_back_to_back;
        int unsigned t0;
        int unsigned base;
        logic [7:0]  bytes [3];
        logic [7:0]  e;
        bytes[0] = 8'hC0;
        bytes[1] = 8'h42;
        bytes[2] = 8'hFF;
        base = rd;
        t0 = cyc;
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 3; i++) send_frame(bytes[i], CPB, 1'b1, 1'b0);
        wait_obs(base + 3, 50);
        for (int i = 0; i < 3; i++) begin
            if (obs_data.size() > rd) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_data[rd] !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, obs_data[rd], e); end
                n_checks++;
                if (i == 0 && obs_cyc[rd] - t0 != DONE_LAT) begin
                    n_fail++;
                    $display("FAIL b2b_latency: got %0d want %0d", obs_cyc[rd] - t0, DONE_LAT);
                end else if (i > 0 && obs_cyc[rd] - obs_cyc[rd-1] != 10 * CPB) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d want %0d", i, obs_cyc[rd] - obs_cyc[rd-1], 10 * CPB);
                end
                rd++;
            end
        end
        step(20);
        n_checks++;
        if (rx_data !== 8'hFF || hold_n != 0) begin
            n_fail++;
            $display("FAIL b2b_hold: data %h holdviol %0d want FF/0", rx_data, hold_n);
        end
    endtask

    task automatic test_glitch;
        int unsigned b0;
        int unsigned n0;
        int unsigned f0;
        b0 = busy_n;
        n0 = obs_data.size();
        f0 = ferr_cyc.size();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        n_checks++;
        if (busy_n - b0 != H) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d want %0d", busy_n - b0, H); end
        n_checks++;
        if (obs_data.size() != n0) begin n_fail++; $display("FAIL glitch_no_done: got %0d want %0d", obs_data.size(), n0); end
        n_checks++;
        if (ferr_cyc.size() != f0) begin n_fail++; $display("FAIL glitch_no_ferr: got %0d want %0d", ferr_cyc.size(), f0); end
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy %b want 0", rx_busy); end
    endtask

    task automatic test_frame_err;
        int unsigned t0;
        int unsigned n0;
        int unsigned f0;
        logic [7:0]  d;
        logic [7:0]  e;
        d  = 8'h55;
        n0 = obs_data.size();
        f0 = ferr_cyc.size();
        t0 = cyc;
        drive_bit(1'b0, CPB, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB, 1'b0);
        rx = 1'b0;
        step(CPB + 100);
        n_checks++;
        if (ferr_cyc.size() != f0 + 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d want %0d", ferr_cyc.size() - f0, 1);
        end else begin
            n_checks++;
            if (ferr_cyc[f0] - t0 != DONE_LAT) begin
                n_fail++;
                $display("FAIL ferr_latency: got %0d want %0d", ferr_cyc[f0] - t0, DONE_LAT);
            end
        end
        n_checks++;
        if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL ferr_data_kept: got %h want FF", rx_data); end
        n_checks++;
        if (obs_data.size() != n0) begin n_fail++; $display("FAIL ferr_no_done: got %0d want %0d", obs_data.size(), n0); end
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b want 1", rx_busy); end
        rx = 1'b1;
        step(6);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_idle: got %b want 0", rx_busy); end
        exp_q.push_back(8'h01);
        send_frame(8'h01, CPB, 1'b1, 1'b0);
        wait_obs(rd + 1, 50);
        if (obs_data.size() > rd) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_data[rd] !== e) begin n_fail++; $display("FAIL ferr_recover_data: got %h want %h", obs_data[rd], e); end
            rd++;
        end
    endtask

    task automatic test_reset_mid;
        int unsigned n0;
        int unsigned f0;
        logic [7:0]  d;
        logic [7:0]  e;
        d  = 8'hB1;
        n0 = obs_data.size();
        f0 = ferr_cyc.size();
        drive_bit(1'b0, CPB, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], CPB, 1'b0);
        drive_bit(d[4], H, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_done, rx_data, frame_err, rx_busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 000", {rx_done, rx_data, frame_err, rx_busy});
        end
        rx = 1'b1;
        step(4);
        rst_n = 1'b1;
        step(12 * CPB);
        n_checks++;
        if (obs_data.size() != n0) begin n_fail++; $display("FAIL midreset_no_done: got %0d want %0d", obs_data.size(), n0); end
        n_checks++;
        if (ferr_cyc.size() != f0) begin n_fail++; $display("FAIL midreset_no_ferr: got %0d want %0d", ferr_cyc.size(), f0); end
        exp_q.push_back(8'hB2);
        send_frame(8'hB2, CPB, 1'b1, 1'b0);
        wait_obs(rd + 1, 50);
        if (obs_data.size() > rd) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_data[rd] !== e) begin n_fail++; $display("FAIL midreset_b2_data: got %h want %h", obs_data[rd], e); end
            rd++;
        end
    endtask

    task automatic test_baud;
        logic [7:0] e;
        exp32_q.push_back(8'h3C);
        send_frame(8'h3C, CPB32 - 1, 1'b1, 1'b1);
        exp32_q.push_back(8'h3C);
        send_frame(8'h3C, CPB32 + 1, 1'b1, 1'b1);
        step(2 * CPB32);
        n_checks++;
        if (obs32.size() != 2) begin n_fail++; $display("FAIL baud_count: got %0d want 2", obs32.size()); end
        while (exp32_q.size() > 0 && obs32.size() > rd32) begin
            e = exp32_q.pop_front();
            n_checks++;
            if (obs32[rd32] !== e) begin n_fail++; $display("FAIL baud_data%0d: got %h want %h", rd32, obs32[rd32], e); end
            rd32++;
        end
        n_checks++;
        if (ferr32_n != 0) begin n_fail++; $display("FAIL baud_no_ferr: got %0d want 0", ferr32_n); end
    endtask

    task automatic test_strobes;
        n_checks++;
        if (overlap_n != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d want 0", overlap_n); end
        n_checks++;
        if (width_n != 0) begin n_fail++; $display("FAIL strobe_width: got %0d want 0", width_n); end
        n_checks++;
        if (hold_n != 0) begin n_fail++; $display("FAIL data_hold: got %0d want 0", hold_n); end
        n_checks++;
        if (exp_q.size() != 0 || rd != obs_data.size()) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending %0d extra %0d want 0/0", exp_q.size(), obs_data.size() - rd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_baud();
        test_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
